// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if -- request/grant bus between eight requesters and the
// round-robin arbiter that drives the 8x1 data mux.
//
// Handshake: req[i] is a level request held by requester i for as long as it
// wants the mux.  gnt/sel/valid are registered by the arbiter; valid=1 means
// gnt is one-hot with gnt[sel]=1 and dout carries din[sel] in that same cycle.
// There is no ready/backpressure path: a requester consumes its grant by
// keeping req high and releases it by dropping req.
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       dout;

    // Requester side: drives requests and data, observes the grant.
    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  valid,
        input  dout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output valid,
        output dout
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter -- 8-input round-robin arbiter steering an 8x1 bit mux.
//
// Two-state FSM (IDLE / GRANT).  A rotating pointer sets where the search for
// the next winner starts, so every requester is reached within seven other
// tenures.  A released grant hands over to the next pending requester on the
// following edge without an idle bubble.
//
// Optional build macro ARB_TIMEOUT_EN: adds a hold counter that forces
// rotation after HOLD_MAX consecutive grant cycles when another requester is
// waiting.  Without the macro the arbiter is non-preemptive.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = GRANT).
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux8_rr_arbiter_if.slave    bus,
    output logic                dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Legal HOLD_MAX is 1..255; an out-of-range setting elaborates this
    // marker block so it is visible in the design hierarchy.
    if (HOLD_MAX == 0 || HOLD_MAX > 255) begin : g_hold_max_illegal
    end

    state_t     state;
    logic [7:0] gnt_q;
    logic [2:0] sel_q;
    logic       valid_q;
    logic [2:0] ptr;

    // Search result helpers: {found, index}.
    logic       any_found;
    logic [2:0] any_idx;
    logic       oth_found;
    logic [2:0] oth_idx;
    logic [7:0] other_req;

    // Next-action decode.
    logic       load;
    logic [2:0] load_idx;
    logic       drop;
    logic       hold_done;

    // First set bit of r scanning start, start+1, ... modulo 8.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        // Scan from the farthest offset down so the nearest hit is kept last.
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;

    // The current owner has used up its tenure once the counter reaches the last slot.
    assign hold_done = (hold_cnt == HOLD_LAST);

    // Count consecutive cycles of one grant; restart on every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
        end else if (load || drop) begin
            hold_cnt <= 8'd0;
        end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    // Non-preemptive build: a tenure never expires.
    assign hold_done = 1'b0;
`endif

    // Winner searches: among all requests, and among requests other than the current owner.
    always_comb begin
        other_req              = bus.req & ~gnt_q;
        {any_found, any_idx}   = pick(bus.req, ptr);
        {oth_found, oth_idx}   = pick(other_req, ptr);
    end

    // Decide whether the next edge loads a new grant, drops to idle, or holds.
    always_comb begin
        load     = 1'b0;
        load_idx = any_idx;
        drop     = 1'b0;
        case (state)
            IDLE: begin
                if (any_found) begin
                    load     = 1'b1;
                    load_idx = any_idx;
                end
            end
            GRANT: begin
                if (bus.req[sel_q] && !(hold_done && oth_found)) begin
                    // Owner keeps the mux.
                    load = 1'b0;
                end else if (oth_found) begin
                    // Released or timed out: hand over with no bubble.
                    load     = 1'b1;
                    load_idx = oth_idx;
                end else begin
                    drop = 1'b1;
                end
            end
            default: begin
                drop = 1'b1;
            end
        endcase
    end

    // FSM with registered grant outputs and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
            ptr     <= 3'd0;
        end else if (load) begin
            state   <= GRANT;
            gnt_q   <= 8'h01 << load_idx;
            sel_q   <= load_idx;
            valid_q <= 1'b1;
            // Natural 3-bit wrap takes requester 7 back to 0.
            ptr     <= load_idx + 3'd1;
        end else if (drop) begin
            state   <= IDLE;
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
        end
    end

    // Outputs: registered grant state plus the combinational data mux.
    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.dout  = valid_q ? bus.din[sel_q] : 1'b0;
    assign dbg_state = (state == GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter -- directed bench for mux8_rr_arbiter (HOLD_MAX = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mux8_rr_arbiter;

    localparam int unsigned HOLD_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic dbg_state;

    always #5 clk = ~clk;

    mux8_rr_arbiter_if bus();

    mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        bus.req = 8'h00;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    // ---------------- invariant monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests_run++;
            if (((bus.gnt & (bus.gnt - 8'h01)) != 8'h00) ||
                (bus.valid && !bus.gnt[bus.sel]) ||
                (!bus.valid && bus.gnt != 8'h00) ||
                (dbg_state !== bus.valid)) begin
                tests_failed++;
                $display("FAIL invariant: gnt=%h sel=%0d valid=%b state=%b, required one-hot gnt with gnt[sel]=1 when valid, state=valid",
                         bus.gnt, bus.sel, bus.valid, dbg_state);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req = 8'h00;
        bus.din = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid, bus.dout, dbg_state} !== {8'h00, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_async: gnt=%h sel=%0d valid=%b dout=%b state=%b, expected all zero",
                     bus.gnt, bus.sel, bus.valid, bus.dout, dbg_state);
        end
        #5 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL reset_idle[%0d]: gnt=%h sel=%0d valid=%b dout=%b, expected gnt=00 sel=0 valid=0 dout=0",
                         c, bus.gnt, bus.sel, bus.valid, bus.dout);
            end
        end
    endtask

    task automatic test_single();
        bus.din = 8'hAA;
        bus.req = 8'h08;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h08, 3'd3, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_grant: gnt=%h sel=%0d valid=%b dout=%b, expected gnt=08 sel=3 valid=1 dout=1",
                     bus.gnt, bus.sel, bus.valid, bus.dout);
        end
        bus.req = 8'h00;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h00, 3'd3, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_release: gnt=%h sel=%0d valid=%b dout=%b, expected gnt=00 sel=3 valid=0 dout=0",
                     bus.gnt, bus.sel, bus.valid, bus.dout);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bus.din = 8'hAA;
        bus.req = 8'h81;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL simul_first: gnt=%h sel=%0d valid=%b dout=%b, expected gnt=01 sel=0 valid=1 dout=0",
                     bus.gnt, bus.sel, bus.valid, bus.dout);
        end
        bus.req = 8'h80;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h80, 3'd7, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL simul_handover: gnt=%h sel=%0d valid=%b dout=%b, expected gnt=80 sel=7 valid=1 dout=1",
                     bus.gnt, bus.sel, bus.valid, bus.dout);
        end
        bus.req = 8'h00;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid} !== {8'h00, 3'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL simul_idle: gnt=%h sel=%0d valid=%b, expected gnt=00 sel=7 valid=0",
                     bus.gnt, bus.sel, bus.valid);
        end
        bus.req = 8'h81;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid} !== {8'h01, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL simul_wrap: gnt=%h sel=%0d valid=%b, expected gnt=01 sel=0 valid=1 (ptr wrapped to 0)",
                     bus.gnt, bus.sel, bus.valid);
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        logic [7:0] exp_gnt;
        apply_reset();
        bus.req = 8'h03;
        for (int k = 0; k < 16; k++) begin
            tick();
`ifdef ARB_TIMEOUT_EN
            exp_gnt = (((k / 4) % 2) == 1) ? 8'h02 : 8'h01;
`else
            exp_gnt = 8'h01;
`endif
            tests_run++;
            if ({bus.gnt, bus.valid} !== {exp_gnt, 1'b1}) begin
                tests_failed++;
                $display("FAIL timeout[%0d]: gnt=%h valid=%b, expected gnt=%h valid=1",
                         k, bus.gnt, bus.valid, exp_gnt);
            end
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        bus.din = 8'hAA;
        bus.req = 8'h20;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h20, 3'd5, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL midrst_pre: gnt=%h sel=%0d valid=%b dout=%b, expected gnt=20 sel=5 valid=1 dout=1",
                     bus.gnt, bus.sel, bus.valid, bus.dout);
        end
        bus.req = 8'h21;
        rst_n   = 1'b0;
        #1;
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midrst_drop: gnt=%h sel=%0d valid=%b dout=%b, expected all zero before next edge",
                     bus.gnt, bus.sel, bus.valid, bus.dout);
        end
        #1 rst_n = 1'b1;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel, bus.valid} !== {8'h01, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL midrst_restart: gnt=%h sel=%0d valid=%b, expected gnt=01 sel=0 valid=1",
                     bus.gnt, bus.sel, bus.valid);
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_select_sweep();
        apply_reset();
        bus.din = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            bus.req = 8'h01 << i;
            tick();
            tests_run++;
            if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {8'h01 << i, 3'(i), 1'b1, 1'(i % 2)}) begin
                tests_failed++;
                $display("FAIL sweep[%0d]: gnt=%h sel=%0d valid=%b dout=%b, expected gnt=%h sel=%0d valid=1 dout=%0d",
                         i, bus.gnt, bus.sel, bus.valid, bus.dout, 8'h01 << i, i, i % 2);
            end
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.req = 8'h16;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel} !== {8'h02, 3'd1}) begin
            tests_failed++;
            $display("FAIL rr_first: gnt=%h sel=%0d, expected gnt=02 sel=1", bus.gnt, bus.sel);
        end
        bus.req = 8'h14;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel} !== {8'h04, 3'd2}) begin
            tests_failed++;
            $display("FAIL rr_second: gnt=%h sel=%0d, expected gnt=04 sel=2", bus.gnt, bus.sel);
        end
        bus.req = 8'h12;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel} !== {8'h10, 3'd4}) begin
            tests_failed++;
            $display("FAIL rr_skip_low: gnt=%h sel=%0d, expected gnt=10 sel=4", bus.gnt, bus.sel);
        end
        bus.req = 8'h02;
        tick();
        tests_run++;
        if ({bus.gnt, bus.sel} !== {8'h02, 3'd1}) begin
            tests_failed++;
            $display("FAIL rr_wrap: gnt=%h sel=%0d, expected gnt=02 sel=1", bus.gnt, bus.sel);
        end
        bus.req = 8'h00;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_reset_mid_grant();
        test_select_sweep();
        test_round_robin();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
